// File: rtl/demux6_reg_pkg.sv
// Shared definitions for the registered 1-to-6 demultiplexer.
//   NCH      : number of output channels
//   onehot6  : 1 when a select vector has exactly one bit set (a legal select)
//   slice_lo : low bit index of channel ch inside a packed NCH*dw data bus
package demux6_reg_pkg;

    localparam int NCH = 6;

    function automatic logic onehot6(input logic [NCH-1:0] sel);
        return $countones(sel) == 1;
    endfunction

    function automatic int slice_lo(input int ch, input int dw);
        return ch * dw;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with a valid/ready output side.
//   clk, reset : clock, asynchronous active-high reset
//   push       : load din this cycle (wins over a pop)
//   din        : incoming beat data
//   pop_ready  : downstream ready for this slot
//   valid      : slot holds a beat
//   dout       : held beat; only changes on push
//   can_take   : slot is empty or is draining this cycle
module demux_slot #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop_ready,
    output logic          valid,
    output logic [DW-1:0] dout,
    output logic          can_take
);

    // A full slot whose beat leaves this cycle can accept a replacement,
    // giving one beat per cycle of throughput.
    assign can_take = ~valid | pop_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (push) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (pop_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux6_reg.sv
// Registered 1-to-6 demultiplexer with one-hot destination select.
//   clk, reset : clock, asynchronous active-high reset
//   in_valid   : input beat valid
//   in_sel     : one-hot destination select, bit i -> channel i
//   in_data    : input beat data
//   in_ready   : input beat accepted when in_valid & in_ready
//   out_valid  : per-channel valid
//   out_data   : channel i at [i*DW +: DW]
//   out_ready  : per-channel downstream ready
//   err        : sticky, set on any dropped (illegal-select) beat
//   drop_count : saturating count of dropped beats
module demux6_reg
    import demux6_reg_pkg::*;
#(
    parameter int DW = 1,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [NCH-1:0]    in_sel,
    input  logic [DW-1:0]     in_data,
    output logic              in_ready,
    output logic [NCH-1:0]    out_valid,
    output logic [NCH*DW-1:0] out_data,
    input  logic [NCH-1:0]    out_ready,
    output logic              err,
    output logic [CW-1:0]     drop_count
);

    logic           legal;
    logic           drop;
    logic [NCH-1:0] can_take;
    logic [NCH-1:0] push;

    assign legal = onehot6(in_sel);

    // Illegal selects are always consumed so the upstream never stalls on them.
    // Deliberately independent of in_valid.
    assign in_ready = legal ? |(in_sel & can_take) : 1'b1;

    assign push = {NCH{in_valid & in_ready & legal}} & in_sel;
    assign drop = in_valid & ~legal;

    for (genvar i = 0; i < NCH; i++) begin : g_slot
        demux_slot #(.DW(DW)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .push      (push[i]),
            .din       (in_data),
            .pop_ready (out_ready[i]),
            .valid     (out_valid[i]),
            .dout      (out_data[slice_lo(i, DW) +: DW]),
            .can_take  (can_take[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err        <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            err <= 1'b1;
            if (drop_count != {CW{1'b1}})
                drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_demux6_reg.sv
module tb_demux6_reg;

    localparam int DW  = 8;
    localparam int CW  = 2;
    localparam int SAT = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic [5:0]     in_sel = '0;
    logic [DW-1:0]  in_data = '0;
    logic           in_ready;
    logic [5:0]     out_valid;
    logic [6*DW-1:0] out_data;
    logic [5:0]     out_ready = 6'h3F;
    logic           err;
    logic [CW-1:0]  drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model: each channel is a capacity-1 queue of pending beats.
    logic [DW-1:0] exp_q [6][$];
    logic          m_err = 1'b0;
    int            m_cnt = 0;

    demux6_reg #(.DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .err        (err),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: runs mid-cycle while inputs and DUT state are stable.
    logic [5:0] ov_exp;
    logic       m_legal;
    logic       rdy_exp;
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 6; i++) ov_exp[i] = (exp_q[i].size() != 0);
            check("out_valid", 64'(out_valid), 64'(ov_exp));
            for (int i = 0; i < 6; i++)
                if (ov_exp[i])
                    check($sformatf("out_data_ch%0d", i), 64'(out_data[i*DW +: DW]), 64'(exp_q[i][0]));
            check("err", 64'(err), 64'(m_err));
            check("drop_count", 64'(drop_count), 64'(m_cnt));

            m_legal = ($countones(in_sel) == 1);
            rdy_exp = 1'b1;
            if (m_legal)
                for (int i = 0; i < 6; i++)
                    if (in_sel[i]) rdy_exp = !ov_exp[i] || out_ready[i];
            check("in_ready", 64'(in_ready), 64'(rdy_exp));

            for (int i = 0; i < 6; i++)
                if (ov_exp[i] && out_ready[i]) void'(exp_q[i].pop_front());
            if (in_valid) begin
                if (!m_legal) begin
                    m_err = 1'b1;
                    if (m_cnt < SAT) m_cnt++;
                end else if (rdy_exp) begin
                    for (int i = 0; i < 6; i++)
                        if (in_sel[i]) exp_q[i].push_back(in_data);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [5:0] s, input logic [DW-1:0] d, input logic [5:0] r);
        @(posedge clk);
        #1;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        out_ready = r;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_drop_count"}, 64'(drop_count), 64'd0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) exp_q[i].delete();
        m_err = 1'b0;
        m_cnt = 0;
        #1;
        check_cleared("midrst");
        @(posedge clk);
        #1;
        check_cleared("inrst");
        reset = 1'b0;
    endtask

    logic [5:0] one6 = 6'b000001;
    logic [5:0] rs;
    int         pick;

    initial begin
        // Power-on reset with all downstream ready.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_cleared("por");
        reset = 1'b0;

        // Single routing to channel 2, held through 5 stall cycles, then drained.
        drive(1'b1, 6'b000100, 8'hA5, 6'h00);
        for (int k = 0; k < 5; k++) drive(1'b0, 6'b000100, 8'h00, 6'h00);
        drive(1'b0, 6'h00, 8'h00, 6'b000100);
        drive(1'b0, 6'h00, 8'h00, 6'h00);

        // Backpressure isolation: fill channel 3, retry it, then divert to channel 0.
        drive(1'b1, 6'b001000, 8'h3C, 6'h00);
        drive(1'b1, 6'b001000, 8'h77, 6'h00);
        drive(1'b1, 6'b001000, 8'h78, 6'h00);
        drive(1'b1, 6'b000001, 8'h11, 6'h00);
        drive(1'b0, 6'h00, 8'h00, 6'h00);
        drive(1'b0, 6'h00, 8'h00, 6'h3F);

        // Streaming 0..9 to channel 5.
        for (int k = 0; k < 10; k++) drive(1'b1, 6'b100000, DW'(k), 6'b100000);
        drive(1'b0, 6'h00, 8'h00, 6'h3F);

        // Illegal selects, then saturation of the 2-bit counter.
        drive(1'b1, 6'b000000, 8'hE1, 6'h00);
        drive(1'b1, 6'b000011, 8'hE2, 6'h00);
        drive(1'b1, 6'b100001, 8'hE3, 6'h00);
        drive(1'b0, 6'h00, 8'h00, 6'h00);
        for (int k = 0; k < 5; k++) drive(1'b1, 6'b111111, 8'hEE, 6'h00);
        drive(1'b0, 6'h00, 8'h00, 6'h00);
        drive(1'b0, 6'h00, 8'h00, 6'h00);

        // Reset mid-transfer with beats held.
        drive(1'b1, 6'b010000, 8'h5A, 6'h00);
        mid_reset();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            pick = int'($urandom_range(0, 9));
            if (pick < 7) rs = one6 << $urandom_range(0, 5);
            else          rs = 6'($urandom);
            drive(1'($urandom_range(0, 3) != 0), rs, DW'($urandom), 6'($urandom));
            if (n % 1000 == 999) mid_reset();
        end
        drive(1'b0, 6'h00, 8'h00, 6'h3F);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
